slurm16_mem_arbiter: RTL and testbench
======================================

# slurm16_mem_arbiter

Sequences the single 16-bit memory port of the slurm16 processor and shares it between two requesters: the pipeline's instruction-fetch port (IF) and its load/store port (LS). It sits between `pipeline16` and `memory_controller`, owning `mem_OEb`/`mem_WRb`/address/write-data. It runs one access at a time through a small FSM with a configurable read latency. LS has priority, and a streak counter guarantees that IF cannot be starved.

## Interface
- `BITS`, 16, data width
- `ADDRESS_BITS`, 16, address width
- `MEM_LAT`, 2, read latency in cycles from the OEb assertion to the data being valid (≥1)
- `LS_BURST_MAX`, 3, maximum consecutive LS grants while `if_req` is pending (≥1)

Ports:
- `CLK`  in  1  sole clock, rising edge
- `RSTb`  in  1  asynchronous, active-low reset
- `if_req`  in  1  fetch request
- `if_addr`  in  ADDRESS_BITS  fetch address
- `if_gnt`  out  1  fetch accepted this cycle
- `if_rvalid`  out  1  one-cycle pulse; `if_rdata` valid
- `if_rdata`  out  BITS  fetched word
- `ls_req`  in  1  load/store request
- `ls_we`  in  1  1 = store, 0 = load
- `ls_addr`  in  ADDRESS_BITS  load/store address
- `ls_wdata`  in  BITS  store data
- `ls_gnt`  out  1  load/store accepted this cycle
- `ls_rvalid`  out  1  one-cycle pulse for loads only
- `ls_rdata`  out  BITS  loaded word
- `mem_addr`  out  ADDRESS_BITS  registered memory address
- `mem_wdata`  out  BITS  registered store data
- `mem_rdata`  in  BITS  memory read data
- `mem_OEb`  out  1  active-low read strobe
- `mem_WRb`  out  1  active-low write strobe

## Operation
- FSM states:
  - `ARB_IDLE`: grants are issued only in this state.
  - `ARB_READ`: `mem_OEb`=0, held for MEM_LAT cycles by a down-counter.
  - `ARB_WRITE`: `mem_WRb`=0 for exactly 1 cycle.
- Grants are combinational from the requests and the current state. At most one `*_gnt` is high in a cycle.
- Arbitration in IDLE:
  - If `ls_req` and not (`if_req` and streak==LS_BURST_MAX), LS wins.
  - Otherwise, if `if_req`, IF wins.
- Streak counter:
  - Increments on each LS grant while `if_req`=1.
  - Clears on an IF grant, or in any cycle with `if_req`=0.
  - Saturates at LS_BURST_MAX.
- On the grant edge, the winner's address (and, for a store, `ls_wdata`) is registered into `mem_addr`/`mem_wdata`. The owner tag is registered at the same edge.
  - Next state is READ for IF or LS loads, WRITE for LS stores.
- READ exit: `mem_rdata` is sampled on the last READ edge into the owner's `*_rdata`. The owner's `*_rvalid` pulses for one cycle, and the FSM returns to IDLE.
- WRITE exits to IDLE after its single cycle. Stores produce no rvalid.
- Requesters hold `req`, address and data until `gnt`. Dropping `req` before `gnt` is legal and produces no access. Inputs are ignored outside the grant cycle.
- `*_rdata` holds its last value until it is overwritten.
- Reset, asynchronous and mid-operation allowed:
  - FSM to IDLE, streak to 0, any in-flight access aborted.
  - `mem_OEb`=1, `mem_WRb`=1, `mem_addr`=0, `mem_wdata`=0.
  - Both `gnt`=0, both `rvalid`=0, both `rdata`=0.
  - No rvalid is issued for an aborted read.

## Timing
- Read (cycle 0 = grant):
  - Cycles 1..MEM_LAT: `mem_OEb`=0, `mem_addr` stable.
  - Cycle MEM_LAT+1: `*_rvalid`=1 and the FSM is back in IDLE. A new grant may occur in the same cycle.
- Read latency is MEM_LAT+1 cycles from grant to rvalid. Read throughput is one read per MEM_LAT+1 cycles.
- Store: cycle 1 has `mem_WRb`=0; cycle 2 is IDLE. One store per 2 cycles.
- `mem_OEb` and `mem_WRb` are never low in the same cycle, and both are registered (glitch-free).
- The latency counter is `$clog2(MEM_LAT+1)` bits wide and loads MEM_LAT on the grant edge.

## Structure
- `slurm16_pkg`:
  - `arb_state_t` enum {ARB_IDLE, ARB_READ, ARB_WRITE}
  - `arb_owner_t` enum {OWN_IF, OWN_LS}
- Sub-module `slurm16_arb_pick`: combinational winner selection plus the registered streak counter, parameterised by LS_BURST_MAX.
- The top-level module holds the FSM, latency counter, address/data registers and the rdata/rvalid steering.
- Target size is about 200 lines of RTL.

## Test plan
All scenarios use MEM_LAT=2 and LS_BURST_MAX=3.
1. **IF read:** IF read of 0x0010, memory returns 0xBEEF.
   - `if_gnt` in cycle 0.
   - `mem_OEb`=0 in cycles 1–2 with `mem_addr`=0x0010.
   - `if_rvalid`=1 with `if_rdata`=0xBEEF in cycle 3; `ls_rvalid` stays 0.
2. **LS store:** LS store of 0x1234 to 0x8000.
   - `mem_WRb`=0 for exactly one cycle, with `mem_addr`=0x8000 and `mem_wdata`=0x1234.
   - No rvalid; next grant possible in cycle 2.
3. **Simultaneous requests:** `if_req` and `ls_req` rise together.
   - LS is granted first; IF is granted in the first IDLE cycle after the LS access.
4. **Starvation guard:** `if_req` held high, LS issues back-to-back loads.
   - Exactly 3 LS grants, then 1 IF grant, then LS resumes.
5. **Reset mid-read:** `RSTb` pulsed low during cycle 1 of a read.
   - All outputs take their reset values immediately.
   - No rvalid follows; the first request after release is granted in IDLE.
6. **Request withdrawal:** `ls_req` dropped while an IF read is in progress.
   - No LS access occurs and `ls_gnt` never asserts.

Source files
------------

// File: rtl/slurm16_pkg.sv
// Shared types for the slurm16 memory arbiter: FSM states and access owner tags.
package slurm16_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_READ  = 2'd1,
        ARB_WRITE = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/slurm16_arb_pick.sv
// Winner selection between fetch and load/store, with the LS streak counter
// that forces an IF grant after LS_BURST_MAX consecutive LS wins.
module slurm16_arb_pick #(
    parameter int LS_BURST_MAX = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic arb_en,
    input  logic if_req,
    input  logic ls_req,
    output logic if_gnt,
    output logic ls_gnt
);

    localparam int STREAK_W = $clog2(LS_BURST_MAX + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(LS_BURST_MAX);

    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                ls_yield;

    assign ls_yield = if_req && (streak_q == STREAK_MAX);

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        ls_gnt   = arb_en && ls_req && !ls_yield;
        if_gnt   = arb_en && if_req && !ls_gnt;
        streak_d = streak_q;
        if (!if_req || if_gnt) begin
            streak_d = '0;
        end else if (ls_gnt && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + STREAK_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/slurm16_mem_arbiter.sv
// Sequences the single slurm16 memory port between instruction fetch and load/store,
// one access at a time, with registered strobes and a MEM_LAT-cycle read window.
module slurm16_mem_arbiter
    import slurm16_pkg::*;
#(
    parameter int BITS         = 16,
    parameter int ADDRESS_BITS = 16,
    parameter int MEM_LAT      = 2,
    parameter int LS_BURST_MAX = 3
) (
    input  logic                    CLK,
    input  logic                    RSTb,
    input  logic                    if_req,
    input  logic [ADDRESS_BITS-1:0] if_addr,
    output logic                    if_gnt,
    output logic                    if_rvalid,
    output logic [BITS-1:0]         if_rdata,
    input  logic                    ls_req,
    input  logic                    ls_we,
    input  logic [ADDRESS_BITS-1:0] ls_addr,
    input  logic [BITS-1:0]         ls_wdata,
    output logic                    ls_gnt,
    output logic                    ls_rvalid,
    output logic [BITS-1:0]         ls_rdata,
    output logic [ADDRESS_BITS-1:0] mem_addr,
    output logic [BITS-1:0]         mem_wdata,
    input  logic [BITS-1:0]         mem_rdata,
    output logic                    mem_OEb,
    output logic                    mem_WRb
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT);

    arb_state_t              state_q, state_d;
    arb_owner_t              owner_q, owner_d;
    logic [CNT_W-1:0]        lat_cnt_q, lat_cnt_d;
    logic [ADDRESS_BITS-1:0] mem_addr_q, mem_addr_d;
    logic [BITS-1:0]         mem_wdata_q, mem_wdata_d;
    logic                    mem_oeb_q, mem_oeb_d;
    logic                    mem_wrb_q, mem_wrb_d;
    logic                    if_rvalid_q, if_rvalid_d;
    logic                    ls_rvalid_q, ls_rvalid_d;
    logic [BITS-1:0]         if_rdata_q, if_rdata_d;
    logic [BITS-1:0]         ls_rdata_q, ls_rdata_d;
    logic                    arb_en;
    logic                    pick_if_gnt, pick_ls_gnt;

    // Grants are suppressed while reset is held, even though the FSM already sits in IDLE.
    assign arb_en = (state_q == ARB_IDLE) && RSTb;

    slurm16_arb_pick #(
        .LS_BURST_MAX(LS_BURST_MAX)
    ) u_pick (
        .clk   (CLK),
        .rst_n (RSTb),
        .arb_en(arb_en),
        .if_req(if_req),
        .ls_req(ls_req),
        .if_gnt(pick_if_gnt),
        .ls_gnt(pick_ls_gnt)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        lat_cnt_d   = lat_cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_oeb_d   = 1'b1;
        mem_wrb_d   = 1'b1;
        if_rvalid_d = 1'b0;
        ls_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        ls_rdata_d  = ls_rdata_q;

        unique case (state_q)
            ARB_IDLE: begin
                if (pick_ls_gnt) begin
                    owner_d    = OWN_LS;
                    mem_addr_d = ls_addr;
                    lat_cnt_d  = LAT_LOAD;
                    if (ls_we) begin
                        mem_wdata_d = ls_wdata;
                        mem_wrb_d   = 1'b0;
                        state_d     = ARB_WRITE;
                    end else begin
                        mem_oeb_d = 1'b0;
                        state_d   = ARB_READ;
                    end
                end else if (pick_if_gnt) begin
                    owner_d    = OWN_IF;
                    mem_addr_d = if_addr;
                    lat_cnt_d  = LAT_LOAD;
                    mem_oeb_d  = 1'b0;
                    state_d    = ARB_READ;
                end
            end
            ARB_READ: begin
                // Count 1 marks the final read cycle: capture data and release OEb together.
                if (lat_cnt_q == CNT_W'(1)) begin
                    state_d = ARB_IDLE;
                    if (owner_q == OWN_IF) begin
                        if_rdata_d  = mem_rdata;
                        if_rvalid_d = 1'b1;
                    end else begin
                        ls_rdata_d  = mem_rdata;
                        ls_rvalid_d = 1'b1;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q - CNT_W'(1);
                    mem_oeb_d = 1'b0;
                end
            end
            ARB_WRITE: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state_q     <= ARB_IDLE;
            owner_q     <= OWN_IF;
            lat_cnt_q   <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_oeb_q   <= 1'b1;
            mem_wrb_q   <= 1'b1;
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            lat_cnt_q   <= lat_cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_oeb_q   <= mem_oeb_d;
            mem_wrb_q   <= mem_wrb_d;
            if_rvalid_q <= if_rvalid_d;
            ls_rvalid_q <= ls_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            ls_rdata_q  <= ls_rdata_d;
        end
    end

    assign if_gnt    = pick_if_gnt;
    assign ls_gnt    = pick_ls_gnt;
    assign if_rvalid = if_rvalid_q;
    assign ls_rvalid = ls_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign ls_rdata  = ls_rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_OEb   = mem_oeb_q;
    assign mem_WRb   = mem_wrb_q;

endmodule

// File: tb/tb_slurm16_mem_arbiter.sv
// Self-checking bench: a cycle-indexed transaction timeline model checks every cycle,
// directed scenarios pin exact cycles, then randomized traffic with mid-run resets.
module tb_slurm16_mem_arbiter;

    localparam int BITS         = 16;
    localparam int AW           = 16;
    localparam int MEM_LAT      = 2;
    localparam int LS_BURST_MAX = 3;
    localparam int MAXC         = 8000;

    logic          CLK;
    logic          RSTb;
    logic          if_req, ls_req, ls_we;
    logic [AW-1:0] if_addr, ls_addr;
    logic [15:0]   ls_wdata;
    logic          if_gnt, ls_gnt, if_rvalid, ls_rvalid;
    logic [15:0]   if_rdata, ls_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_OEb, mem_WRb;

    slurm16_mem_arbiter #(
        .BITS(BITS), .ADDRESS_BITS(AW), .MEM_LAT(MEM_LAT), .LS_BURST_MAX(LS_BURST_MAX)
    ) dut (
        .CLK(CLK), .RSTb(RSTb),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_OEb(mem_OEb), .mem_WRb(mem_WRb)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memory contents as a pure function of address; data is only driven once OEb
    // has been low for MEM_LAT negedges, so early or late sampling returns 0xDEAD.
    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        if (a == 16'h0010) return 16'hBEEF;
        return {a[7:0], a[15:8]} ^ 16'hC3A5;
    endfunction

    int oe_run;
    assign mem_rdata = (!mem_OEb && oe_run == MEM_LAT) ? mem_fn(mem_addr) : 16'hDEAD;

    int n_checks;
    int n_fail;
    int cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Timeline model: a grant in cycle c books the strobe cycles, the rvalid cycle and
    // the earliest cycle the port is free again.
    bit          exp_oe  [MAXC];
    bit          exp_we  [MAXC];
    bit          exp_irv [MAXC];
    bit          exp_lrv [MAXC];
    logic [15:0] exp_a   [MAXC];
    logic [15:0] exp_wd  [MAXC];
    logic [15:0] exp_rd  [MAXC];
    int          free_at;
    int          streak;
    logic [15:0] m_if_rdata, m_ls_rdata;
    bit          m_if_gnt, m_ls_gnt;

    task automatic book_read(input int c, input bit is_ls, input logic [15:0] a);
        for (int k = 1; k <= MEM_LAT; k++) begin
            exp_oe[c+k] = 1'b1;
            exp_a[c+k]  = a;
        end
        if (is_ls) exp_lrv[c+MEM_LAT+1] = 1'b1;
        else       exp_irv[c+MEM_LAT+1] = 1'b1;
        exp_rd[c+MEM_LAT+1] = mem_fn(a);
        free_at = c + MEM_LAT + 1;
    endtask

    always @(negedge CLK) begin
        if (!mem_OEb) oe_run++;
        else          oe_run = 0;

        if (cyc >= MAXC - 8) begin
            $display("FAIL cycle_budget exceeded: got %0d, limit %0d", cyc, MAXC - 8);
            $fatal(1, "cycle budget exhausted");
        end

        if (!RSTb) begin
            check("rst_if_gnt", 32'(if_gnt), 0);
            check("rst_ls_gnt", 32'(ls_gnt), 0);
            check("rst_if_rvalid", 32'(if_rvalid), 0);
            check("rst_ls_rvalid", 32'(ls_rvalid), 0);
            check("rst_if_rdata", 32'(if_rdata), 0);
            check("rst_ls_rdata", 32'(ls_rdata), 0);
            check("rst_mem_OEb", 32'(mem_OEb), 1);
            check("rst_mem_WRb", 32'(mem_WRb), 1);
            check("rst_mem_addr", 32'(mem_addr), 0);
            check("rst_mem_wdata", 32'(mem_wdata), 0);
            for (int i = cyc; i < cyc + MEM_LAT + 3; i++) begin
                exp_oe[i] = 1'b0; exp_we[i] = 1'b0; exp_irv[i] = 1'b0; exp_lrv[i] = 1'b0;
            end
            free_at    = cyc;
            streak     = 0;
            m_if_rdata = '0;
            m_ls_rdata = '0;
            m_if_gnt   = 1'b0;
            m_ls_gnt   = 1'b0;
        end else begin
            m_ls_gnt = (cyc >= free_at) && ls_req && !(if_req && streak == LS_BURST_MAX);
            m_if_gnt = (cyc >= free_at) && if_req && !m_ls_gnt;
            check("cmp_ls_gnt", 32'(ls_gnt), 32'(m_ls_gnt));
            check("cmp_if_gnt", 32'(if_gnt), 32'(m_if_gnt));

            if (m_ls_gnt && ls_we) begin
                exp_we[cyc+1] = 1'b1;
                exp_a[cyc+1]  = ls_addr;
                exp_wd[cyc+1] = ls_wdata;
                free_at = cyc + 2;
            end else if (m_ls_gnt) begin
                book_read(cyc, 1'b1, ls_addr);
            end else if (m_if_gnt) begin
                book_read(cyc, 1'b0, if_addr);
            end

            if (!if_req || m_if_gnt) streak = 0;
            else if (m_ls_gnt && streak < LS_BURST_MAX) streak++;

            check("cmp_mem_OEb", 32'(mem_OEb), 32'(!exp_oe[cyc]));
            check("cmp_mem_WRb", 32'(mem_WRb), 32'(!exp_we[cyc]));
            if (exp_oe[cyc] || exp_we[cyc]) check("cmp_mem_addr", 32'(mem_addr), 32'(exp_a[cyc]));
            if (exp_we[cyc]) check("cmp_mem_wdata", 32'(mem_wdata), 32'(exp_wd[cyc]));
            if (exp_irv[cyc]) m_if_rdata = exp_rd[cyc];
            if (exp_lrv[cyc]) m_ls_rdata = exp_rd[cyc];
            check("cmp_if_rvalid", 32'(if_rvalid), 32'(exp_irv[cyc]));
            check("cmp_ls_rvalid", 32'(ls_rvalid), 32'(exp_lrv[cyc]));
            check("cmp_if_rdata", 32'(if_rdata), 32'(m_if_rdata));
            check("cmp_ls_rdata", 32'(ls_rdata), 32'(m_ls_rdata));
        end
        cyc++;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        if_req = 1'b0;
        ls_req = 1'b0;
        repeat (n) tick();
    endtask

    int   g_cyc[$];
    int   g_kind[$];
    int   w_cyc[5]  = '{0, 3, 6, 9, 12};
    int   w_kind[5] = '{1, 1, 1, 2, 1};
    bit   if_pend, ls_pend;

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0; oe_run = 0;
        free_at = 0; streak = 0;
        for (int i = 0; i < MAXC; i++) begin
            exp_oe[i] = 0; exp_we[i] = 0; exp_irv[i] = 0; exp_lrv[i] = 0;
            exp_a[i] = '0; exp_wd[i] = '0; exp_rd[i] = '0;
        end
        RSTb = 1'b0;
        if_req = 0; ls_req = 0; ls_we = 0;
        if_addr = '0; ls_addr = '0; ls_wdata = '0;
        repeat (3) tick();
        RSTb = 1'b1;
        idle_cycles(2);

        // 1: IF read of 0x0010 returning 0xBEEF
        tick(); if_req = 1; if_addr = 16'h0010;
        @(negedge CLK); check("t1_if_gnt", 32'(if_gnt), 1); check("t1_ls_gnt", 32'(ls_gnt), 0);
        tick(); if_req = 0;
        @(negedge CLK); check("t1_oeb_c1", 32'(mem_OEb), 0); check("t1_addr_c1", 32'(mem_addr), 32'h0010);
        tick();
        @(negedge CLK); check("t1_oeb_c2", 32'(mem_OEb), 0); check("t1_addr_c2", 32'(mem_addr), 32'h0010);
        tick();
        @(negedge CLK);
        check("t1_if_rvalid", 32'(if_rvalid), 1); check("t1_if_rdata", 32'(if_rdata), 32'hBEEF);
        check("t1_ls_rvalid", 32'(ls_rvalid), 0); check("t1_oeb_c3", 32'(mem_OEb), 1);
        idle_cycles(3);

        // 2: LS store 0x1234 -> 0x8000, next grant in cycle 2
        tick(); ls_req = 1; ls_we = 1; ls_addr = 16'h8000; ls_wdata = 16'h1234;
        @(negedge CLK); check("t2_ls_gnt", 32'(ls_gnt), 1);
        tick(); ls_req = 0; ls_we = 0;
        @(negedge CLK);
        check("t2_wrb_c1", 32'(mem_WRb), 0); check("t2_addr", 32'(mem_addr), 32'h8000);
        check("t2_wdata", 32'(mem_wdata), 32'h1234); check("t2_oeb_c1", 32'(mem_OEb), 1);
        tick(); if_req = 1; if_addr = 16'h0020;
        @(negedge CLK);
        check("t2_wrb_c2", 32'(mem_WRb), 1); check("t2_gnt_c2", 32'(if_gnt), 1);
        check("t2_no_rvalid", 32'(ls_rvalid), 0);
        idle_cycles(4);

        // 3: simultaneous requests, LS first then IF in first IDLE cycle
        tick(); ls_req = 1; ls_we = 0; ls_addr = 16'h0200; if_req = 1; if_addr = 16'h0300;
        @(negedge CLK); check("t3_ls_first", 32'(ls_gnt), 1); check("t3_if_wait", 32'(if_gnt), 0);
        tick(); ls_req = 0;
        @(negedge CLK); check("t3_if_wait_c1", 32'(if_gnt), 0);
        tick();
        @(negedge CLK); check("t3_if_wait_c2", 32'(if_gnt), 0);
        tick();
        @(negedge CLK); check("t3_if_gnt_c3", 32'(if_gnt), 1); check("t3_ls_rvalid", 32'(ls_rvalid), 1);
        idle_cycles(4);

        // 4: starvation guard with IF held and LS loads back-to-back
        for (int c = 0; c < 13; c++) begin
            tick();
            if_req = 1; ls_req = 1; ls_we = 0;
            ls_addr = 16'(16'h0A00 + c); if_addr = 16'(16'h0B00 + c);
            @(negedge CLK);
            if (ls_gnt) begin g_cyc.push_back(c); g_kind.push_back(1); end
            if (if_gnt) begin g_cyc.push_back(c); g_kind.push_back(2); end
        end
        check("t4_grant_count", 32'(g_cyc.size()), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < g_cyc.size()) begin
                check("t4_grant_cycle", 32'(g_cyc[i]), 32'(w_cyc[i]));
                check("t4_grant_kind", 32'(g_kind[i]), 32'(w_kind[i]));
            end else begin
                check("t4_grant_missing", 32'(i), 32'(w_cyc[i]));
            end
        end
        idle_cycles(4);

        // 5: reset pulsed during cycle 1 of a read
        tick(); if_req = 1; if_addr = 16'h0040;
        @(negedge CLK); check("t5_if_gnt", 32'(if_gnt), 1);
        tick(); if_req = 0;
        #2 RSTb = 0;
        #1;
        check("t5_oeb_now", 32'(mem_OEb), 1); check("t5_addr_now", 32'(mem_addr), 0);
        check("t5_rvalid_now", 32'(if_rvalid), 0);
        tick(); RSTb = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK); check("t5_no_rvalid", 32'(if_rvalid), 0);
            tick();
        end
        ls_req = 1; ls_we = 0; ls_addr = 16'h0100;
        @(negedge CLK); check("t5_first_gnt", 32'(ls_gnt), 1);
        idle_cycles(4);

        // 6: LS request withdrawn while an IF read is in progress
        tick(); if_req = 1; if_addr = 16'h0050;
        @(negedge CLK); check("t6_if_gnt", 32'(if_gnt), 1);
        tick(); if_req = 0; ls_req = 1; ls_we = 0; ls_addr = 16'h0777;
        @(negedge CLK); check("t6_no_ls_gnt", 32'(ls_gnt), 0);
        tick(); ls_req = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            check("t6_no_ls_gnt", 32'(ls_gnt), 0);
            check("t6_no_ls_rvalid", 32'(ls_rvalid), 0);
            if (k >= 1) check("t6_oeb_idle", 32'(mem_OEb), 1);
            tick();
        end
        idle_cycles(2);

        // Randomized traffic with withdrawals and occasional mid-cycle resets
        if_pend = 0; ls_pend = 0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            RSTb = 1;
            if (m_if_gnt) if_pend = 0;
            if (m_ls_gnt) ls_pend = 0;
            if (if_pend && $urandom_range(15) == 0) if_pend = 0;
            if (ls_pend && $urandom_range(15) == 0) ls_pend = 0;
            if (!if_pend && $urandom_range(2) == 0) begin
                if_pend = 1;
                if_addr = 16'($urandom);
            end
            if (!ls_pend && $urandom_range(3) != 0) begin
                ls_pend  = 1;
                ls_addr  = 16'($urandom);
                ls_wdata = 16'($urandom);
                ls_we    = 1'($urandom_range(1));
            end
            if_req = if_pend;
            ls_req = ls_pend;
            if (i % 700 == 350) #2 RSTb = 0;
        end
        idle_cycles(5);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
